// File: rtl/npc_mc_core.sv
// npc_mc_core: multi-cycle RV32I-subset core (addi/add/sub/lui/auipc/jal/jalr) with handshaked fetch,
// ebreak/illegal halt and retire reporting. Define NPC_RVE_EN for the 16-register variant.
module npc_mc_core #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
`ifdef NPC_RVE_EN
  parameter int              NREG     = 16
`else
  parameter int              NREG     = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  output logic            if_req,
  output logic [XLEN-1:0] if_addr,
  input  logic            if_valid,
  input  logic [31:0]     if_inst,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic [XLEN-1:0] retire_pc,
  output logic            halted,
  output logic [XLEN-1:0] halt_code
);

  localparam int IDX_W = $clog2(NREG);
  localparam logic [IDX_W-1:0] REG_A0 = IDX_W'(10);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t          state, state_next;
  logic [31:0]     inst, inst_next;
  logic [XLEN-1:0] pc_next, retire_pc_next, halt_code_next;
  logic            retire_next, halted_next;
  logic [XLEN-1:0] gpr [NREG];

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_u, imm_j, rs1_val, rs2_val, link;
  logic [XLEN-1:0] wb_val, jump_target;
  logic            legal, is_jump, is_ebreak, rve_bad, wr_en;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_u = XLEN'($signed({inst[31:12], 12'h000}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  assign rs1_val   = (rs1 == '0) ? '0 : gpr[rs1[IDX_W-1:0]];
  assign rs2_val   = (rs2 == '0) ? '0 : gpr[rs2[IDX_W-1:0]];
  assign link      = pc + XLEN'(4);
  assign is_ebreak = (inst == EBREAK);

`ifdef NPC_RVE_EN
  // Only register fields the format actually decodes may name x16..x31 illegally.
  assign rve_bad = rd[4]
                 | (rs1[4] & (opcode == OPC_OP_IMM || opcode == OPC_OP || opcode == OPC_JALR))
                 | (rs2[4] & (opcode == OPC_OP));
`else
  assign rve_bad = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    legal       = 1'b1;
    is_jump     = 1'b0;
    wb_val      = '0;
    jump_target = '0;
    case (opcode)
      OPC_OP_IMM: begin
        legal  = (funct3 == 3'b000);
        wb_val = rs1_val + imm_i;
      end
      OPC_OP: begin
        legal  = (funct3 == 3'b000) && (funct7 == 7'b0000000 || funct7 == 7'b0100000);
        wb_val = funct7[5] ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
      end
      OPC_LUI:   wb_val = imm_u;
      OPC_AUIPC: wb_val = pc + imm_u;
      OPC_JAL: begin
        wb_val      = link;
        is_jump     = 1'b1;
        jump_target = pc + imm_j;
      end
      OPC_JALR: begin
        legal       = (funct3 == 3'b000);
        wb_val      = link;
        is_jump     = 1'b1;
        jump_target = (rs1_val + imm_i) & ~XLEN'(1);
      end
      default: legal = is_ebreak;
    endcase
    if (rve_bad) legal = 1'b0;
  end

  always_comb begin
    state_next     = state;
    inst_next      = inst;
    pc_next        = pc;
    retire_next    = 1'b0;
    retire_pc_next = retire_pc;
    halted_next    = halted;
    halt_code_next = halt_code;
    wr_en          = 1'b0;
    case (state)
      S_FETCH: begin
        if (if_valid) begin
          inst_next  = if_inst;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!legal) begin
          state_next     = S_HALT;
          halted_next    = 1'b1;
          halt_code_next = '1;
        end else if (is_ebreak) begin
          state_next     = S_HALT;
          halted_next    = 1'b1;
          halt_code_next = gpr[REG_A0];
          retire_next    = 1'b1;
          retire_pc_next = pc;
        end else begin
          state_next     = S_FETCH;
          wr_en          = (rd != '0);
          pc_next        = is_jump ? jump_target : link;
          retire_next    = 1'b1;
          retire_pc_next = pc;
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      inst      <= '0;
      pc        <= RESET_PC;
      retire    <= 1'b0;
      retire_pc <= '0;
      halted    <= 1'b0;
      halt_code <= '0;
    end else begin
      state     <= state_next;
      inst      <= inst_next;
      pc        <= pc_next;
      retire    <= retire_next;
      retire_pc <= retire_pc_next;
      halted    <= halted_next;
      halt_code <= halt_code_next;
    end
  end

  // NOTE: the register file is cleared on reset because software may read any GPR before writing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (wr_en) begin
      gpr[rd[IDX_W-1:0]] <= wb_val;
    end
  end

  assign if_req  = (state == S_FETCH);
  assign if_addr = pc;

endmodule

// File: tb/tb_npc_mc_core.sv
// Self-checking bench for npc_mc_core: an architectural model checked every cycle, directed programs
// with literal expectations, and randomized programs with random fetch stalls and mid-run resets.
module tb_npc_mc_core;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req, if_valid, retire, halted;
  logic [31:0] if_addr, if_inst, pc, retire_pc, halt_code;

  npc_mc_core dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid),
    .if_inst(if_inst), .pc(pc), .retire(retire), .retire_pc(retire_pc),
    .halted(halted), .halt_code(halt_code)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural model: phase 0 = waiting for fetch, 1 = executing, 2 = stopped.
  bit          m_known = 1'b0;
  int          m_phase;
  logic [31:0] m_pc, m_inst, m_retire_pc, m_halt_code;
  logic        m_retire, m_halted;
  logic [31:0] m_regs [32];

  task automatic m_exec();
    logic [31:0] i, a, b, res, npc, simm, uimm, jimm;
    int rd, rs1, rs2;
    bit ill, ebrk, use1, use2;
    i    = m_inst;
    rd   = int'(i[11:7]);
    rs1  = int'(i[19:15]);
    rs2  = int'(i[24:20]);
    a    = m_regs[rs1];
    b    = m_regs[rs2];
    simm = {{20{i[31]}}, i[31:20]};
    uimm = {i[31:12], 12'h000};
    jimm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    npc  = m_pc + 32'd4;
    res  = 32'h0;
    ill  = 1'b0; ebrk = 1'b0; use1 = 1'b0; use2 = 1'b0;
    if (i == EBREAK) ebrk = 1'b1;
    else if (i[6:0] == 7'h13 && i[14:12] == 3'd0) begin res = a + simm; use1 = 1'b1; end
    else if (i[6:0] == 7'h33 && i[14:12] == 3'd0 && i[31:25] == 7'h00) begin res = a + b; use1 = 1'b1; use2 = 1'b1; end
    else if (i[6:0] == 7'h33 && i[14:12] == 3'd0 && i[31:25] == 7'h20) begin res = a - b; use1 = 1'b1; use2 = 1'b1; end
    else if (i[6:0] == 7'h37) res = uimm;
    else if (i[6:0] == 7'h17) res = m_pc + uimm;
    else if (i[6:0] == 7'h6F) begin res = m_pc + 32'd4; npc = m_pc + jimm; end
    else if (i[6:0] == 7'h67 && i[14:12] == 3'd0) begin
      res = m_pc + 32'd4; npc = (a + simm) & 32'hFFFF_FFFE; use1 = 1'b1;
    end else ill = 1'b1;
`ifdef NPC_RVE_EN
    if (!ebrk && !ill && (rd >= 16 || (use1 && rs1 >= 16) || (use2 && rs2 >= 16))) ill = 1'b1;
`endif
    if (ill) begin
      m_phase <= 2; m_halted <= 1'b1; m_halt_code <= 32'hFFFF_FFFF;
    end else if (ebrk) begin
      m_phase <= 2; m_halted <= 1'b1; m_halt_code <= m_regs[10];
      m_retire <= 1'b1; m_retire_pc <= m_pc;
    end else begin
      if (rd != 0) m_regs[rd] <= res;
      m_pc <= npc; m_retire <= 1'b1; m_retire_pc <= m_pc; m_phase <= 0;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_known <= 1'b1; m_phase <= 0; m_pc <= RST_PC; m_inst <= '0;
      m_retire <= 1'b0; m_retire_pc <= '0; m_halted <= 1'b0; m_halt_code <= '0;
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
    end else begin
      m_retire <= 1'b0;
      if (m_phase == 0 && if_valid) begin
        m_inst <= if_inst; m_phase <= 1;
      end else if (m_phase == 1) begin
        m_exec();
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("if_req", {31'd0, if_req}, {31'd0, m_phase == 0});
      check("if_addr", if_addr, m_pc);
      check("pc", pc, m_pc);
      check("retire", {31'd0, retire}, {31'd0, m_retire});
      if (m_retire) check("retire_pc", retire_pc, m_retire_pc);
      check("halted", {31'd0, halted}, {31'd0, m_halted});
      check("halt_code", halt_code, m_halt_code);
    end
  end

  // Stimulus state
  logic [31:0] prog [$];
  logic [31:0] fetch_log [$];
  int valid_pct = 100, stall_cnt = 0, retire_cnt = 0, tick_n = 0, first_fetch = 0;

  function automatic logic [31:0] enc_i(logic [6:0] op, logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [4:0] rd);
    return {f7, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [4:0] pick_reg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 11));
  endfunction

  function automatic logic [31:0] rand_inst(bit allow_ill);
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm12;
    logic [19:0] imm20;
    logic [20:0] imm21;
    int kind;
    rd = pick_reg(); rs1 = pick_reg(); rs2 = pick_reg();
    imm12 = 12'($urandom); imm20 = 20'($urandom); imm21 = 21'($urandom); imm21[0] = 1'b0;
    kind = $urandom_range(0, 19);
    if (kind == 14 && !allow_ill) kind = 0;
    case (kind)
      0, 1, 2, 3: return enc_i(7'h13, 3'd0, rd, rs1, imm12);
      4, 5:       return enc_r(7'h00, rs2, rs1, rd);
      6, 7:       return enc_r(7'h20, rs2, rs1, rd);
      8:          return enc_u(imm20, rd, 7'h37);
      9:          return enc_u(imm20, rd, 7'h17);
      10, 11:     return enc_j(imm21, rd);
      12, 13:     return enc_i(7'h67, 3'd0, rd, rs1, imm12);
      14: case ($urandom_range(0, 2))
            0:       return 32'h0000_0000;
            1:       return enc_r(7'h01, rs2, rs1, rd);
            default: return enc_i(7'h67, 3'd1, rd, rs1, imm12);
          endcase
      default:    return enc_i(7'h13, 3'd0, rd, 5'd0, imm12);
    endcase
  endfunction

  task automatic tick(input bit r);
    @(negedge clk);
    if (retire) retire_cnt++;
    rst = r;
    if (!r) tick_n++;
    if_valid = (stall_cnt > 0) ? 1'b0 : ($urandom_range(1, 100) <= valid_pct);
    if (stall_cnt > 0) stall_cnt--;
    if (if_req === 1'b1) if_inst = (prog.size() > 0) ? prog[0] : EBREAK;
    else                 if_inst = $urandom;
    if (!r && if_req === 1'b1 && if_valid) begin
      if (fetch_log.size() == 0) first_fetch = tick_n;
      fetch_log.push_back(if_addr);
      if (prog.size() > 0) void'(prog.pop_front());
    end
  endtask

  function automatic logic [31:0] log_at(int i);
    return (i < fetch_log.size()) ? fetch_log[i] : 32'hDEAD_BEEF;
  endfunction

  // Two reset cycles, reset-state literals, then run until halt or budget expiry.
  task automatic run_prog(input int pct, input int stall, input int budget, input bit need_halt);
    int n;
    tick(1'b1);
    tick(1'b1);
    check("rst_pc", pc, RST_PC);
    check("rst_if_req", {31'd0, if_req}, 32'd1);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_halt_code", halt_code, 32'd0);
    fetch_log.delete();
    retire_cnt = 0; tick_n = 0; first_fetch = 0;
    valid_pct = pct; stall_cnt = stall;
    n = 0;
    while (halted !== 1'b1 && n < budget) begin
      tick(1'b0);
      n++;
    end
    if (need_halt) begin
      check("halt_reached", {31'd0, halted}, 32'd1);
      tick(1'b0);
      tick(1'b0);
    end
  endtask

  initial begin
    if_valid = 1'b0;
    if_inst  = '0;

    // Reset then fetch: addi x1,x0,5 ; ebreak
    prog = '{32'h0050_0093, EBREAK};
    run_prog(100, 0, 200, 1'b1);
    check("t1_fetches", fetch_log.size(), 32'd2);
    check("t1_addr0", log_at(0), 32'h8000_0000);
    check("t1_addr1", log_at(1), 32'h8000_0004);
    check("t1_retires", retire_cnt, 32'd2);
    check("t1_halt_code", halt_code, 32'd0);

    // x1 observed through a0
    prog = '{32'h0050_0093, enc_i(7'h13, 3'd0, 5'd10, 5'd1, 12'd0), EBREAK};
    run_prog(100, 0, 200, 1'b1);
    check("t1b_x1", halt_code, 32'd5);

    // lui/addi/sub/x0 sequence
    prog = '{enc_u(20'h12345, 5'd10, 7'h37), enc_i(7'h13, 3'd0, 5'd10, 5'd10, 12'h678),
             enc_r(7'h20, 5'd10, 5'd10, 5'd11), enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd7), EBREAK};
    run_prog(100, 0, 200, 1'b1);
    check("t2_halt_code", halt_code, 32'h1234_5678);
    check("t2_retire_pc", retire_pc, 32'h8000_0010);

    // x11 and x0 both zero: a0 = x11 + 0x55 + x0
    prog = '{enc_u(20'h12345, 5'd10, 7'h37), enc_r(7'h20, 5'd10, 5'd10, 5'd11),
             enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd7), enc_i(7'h13, 3'd0, 5'd10, 5'd11, 12'h055),
             enc_r(7'h00, 5'd0, 5'd10, 5'd10), EBREAK};
    run_prog(100, 0, 200, 1'b1);
    check("t2b_x11_x0", halt_code, 32'h0000_0055);

    // jal x1,+8 ; jalr x0,0(x1) ; addi x10,x1,0 ; ebreak
    prog = '{enc_j(21'd8, 5'd1), enc_i(7'h67, 3'd0, 5'd0, 5'd1, 12'd0),
             enc_i(7'h13, 3'd0, 5'd10, 5'd1, 12'd0), EBREAK};
    run_prog(100, 0, 200, 1'b1);
    check("t3_addr1", log_at(1), 32'h8000_0008);
    check("t3_addr2", log_at(2), 32'h8000_0004);
    check("t3_link", halt_code, 32'h8000_0004);

    // jalr target 0x80000011 clears bit 0
    prog = '{enc_u(20'h80000, 5'd5, 7'h37), enc_i(7'h67, 3'd0, 5'd0, 5'd5, 12'h011), EBREAK};
    run_prog(100, 0, 200, 1'b1);
    check("t4_addr2", log_at(2), 32'h8000_0010);
    check("t4_pc", pc, 32'h8000_0010);

    // jalr with rd == rs1 reads the operand before writing the link
    prog = '{enc_u(20'h80000, 5'd5, 7'h37), enc_i(7'h67, 3'd0, 5'd5, 5'd5, 12'h020),
             enc_i(7'h13, 3'd0, 5'd10, 5'd5, 12'd0), EBREAK};
    run_prog(100, 0, 200, 1'b1);
    check("t4b_link", halt_code, 32'h8000_0008);
    check("t4b_pc", pc, 32'h8000_0024);

    // Fetch stall of five cycles after reset
    prog = '{32'h0050_0093, EBREAK};
    run_prog(100, 5, 200, 1'b1);
    check("t5_first_fetch", first_fetch, 32'd6);
    check("t5_retires", retire_cnt, 32'd2);

    // Illegal instruction, then recovery through reset
    prog = '{32'h0000_0000};
    run_prog(100, 0, 200, 1'b1);
    check("t6_halt_code", halt_code, 32'hFFFF_FFFF);
    check("t6_retires", retire_cnt, 32'd0);
    check("t6_if_req", {31'd0, if_req}, 32'd0);
    check("t6_pc", pc, 32'h8000_0000);
    prog = '{enc_i(7'h13, 3'd0, 5'd10, 5'd0, 12'd3), EBREAK};
    run_prog(100, 0, 200, 1'b1);
    check("t7_resume", halt_code, 32'd3);
    check("t7_retires", retire_cnt, 32'd2);

    // addi x16,x0,1 ; addi x10,x16,0 ; ebreak
    prog = '{enc_i(7'h13, 3'd0, 5'd16, 5'd0, 12'd1), enc_i(7'h13, 3'd0, 5'd10, 5'd16, 12'd0), EBREAK};
    run_prog(100, 0, 200, 1'b1);
`ifdef NPC_RVE_EN
    check("t8_rve_halt", halt_code, 32'hFFFF_FFFF);
    check("t8_rve_retires", retire_cnt, 32'd0);
`else
    check("t8_x16", halt_code, 32'd1);
    check("t8_retires", retire_cnt, 32'd3);
`endif

    // Randomized programs, some cut short by a reset mid-execution
    for (int p = 0; p < 12; p++) begin
      prog.delete();
      for (int k = 0; k < 25; k++) prog.push_back(rand_inst(p[0]));
      prog.push_back(EBREAK);
      if (p % 4 == 3) run_prog($urandom_range(30, 100), $urandom_range(0, 3), $urandom_range(3, 15), 1'b0);
      else            run_prog($urandom_range(30, 100), $urandom_range(0, 3), 1500, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/npc_mc_core.md
Name: npc_mc_core

Overview:
- Multi-cycle RV32I-subset execution core. Next generation of the single-cycle addi-only NPC top.
- Adds a handshaked instruction fetch interface, parametrised XLEN, reset PC and register count, and a wider instruction set: addi, add, sub, lui, auipc, jal, jalr.
- Adds a halt path for ebreak and illegal instructions, with retire reporting for the difftest/trace harness.
- Sits between the simulation memory model (fetch side) and the testbench halt/trace monitors.

Parameters:
- XLEN, 32, datapath and register width; only 32 is supported for decode, but widths derive from it.
- RESET_PC, 32'h80000000, PC value loaded on reset.
- NREG, 32, number of architectural registers; must be 32, or 16 when NPC_RVE_EN is defined.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  out  1  fetch request, asserted while in FETCH.
- if_addr  out  XLEN  fetch address, equals pc.
- if_valid  in  1  fetch data valid; instruction accepted when if_req && if_valid.
- if_inst  in  32  fetched instruction word.
- pc  out  XLEN  current architectural PC.
- retire  out  1  one-cycle pulse per completed instruction.
- retire_pc  out  XLEN  PC of the retiring instruction; valid when retire is high.
- halted  out  1  sticky; core stopped.
- halt_code  out  XLEN  x10 (a0) value at ebreak; 32'hFFFFFFFF on illegal instruction.

Behaviour:
- Reset (rst high at posedge), from any state including mid-fetch:
  - state=FETCH, pc=RESET_PC, all GPRs=0.
  - retire=0, retire_pc=0, halted=0, halt_code=0, instruction latch=0.
- States:
  - FETCH: if_req=1. When if_valid=1, latch if_inst and go to EXEC. Otherwise stay; no timeout.
  - EXEC: decode the latched instruction, write rd, update pc, pulse retire for exactly this cycle, then go to FETCH. An ebreak or illegal instruction goes to HALT instead.
  - HALT: if_req=0, no state change, halted=1. Left only by rst.
- Minimum 2 cycles per instruction. if_valid is ignored outside FETCH.
- Decode (opcode/funct3/funct7):
  - addi 0010011/000: rd = rs1 + sext(imm[11:0]).
  - add 0110011/000/0000000: rd = rs1 + rs2.
  - sub 0110011/000/0100000: rd = rs1 - rs2.
  - lui 0110111: rd = {imm[31:12], 12'b0}.
  - auipc 0010111: rd = pc + {imm[31:12], 12'b0}.
  - jal 1101111: rd = pc + 4; pc = pc + sext(J-imm).
  - jalr 1100111/000: t = (rs1 + sext(imm)) & ~1; rd = pc + 4; pc = t. Operands are read before the write, so rd == rs1 works.
  - ebreak is exactly 32'h00100073.
  - All other encodings are illegal.
- Non-jump instructions: pc = pc + 4.
- Arithmetic is modulo 2^XLEN; no overflow flags. PC wrap from 32'hFFFFFFFC to 0 is permitted.
- x0: writes are discarded; reads return 0.
- Misaligned jump targets (bit1 set) are not trapped; pc takes the value as-is.
- ebreak in EXEC:
  - halt_code = x10, halted=1, retire pulses with retire_pc = ebreak PC.
  - pc is not advanced. No GPR write.
- Illegal instruction in EXEC:
  - halt_code = 32'hFFFFFFFF, halted=1, retire=0. pc is held at the illegal PC.
- Outputs are registered except if_req and if_addr, which are decoded from state and pc.

Optional Feature:
- NPC_RVE_EN defined:
  - NREG=16; the register file holds x0..x15.
  - Any decoded rd, rs1 or rs2 field with bit4=1 (for formats that use that field) is treated as an illegal instruction: halt, halt_code=32'hFFFFFFFF.
- NPC_RVE_EN undefined:
  - 32 registers; all register indices are legal.

Test Plan:
- Reset then fetch: rst 2 cycles, if_valid=1 constantly, stream addi x1,x0,5 (32'h00500093) then ebreak -> if_addr 80000000 then 80000004; x1=5; retire twice; halted=1; halt_code=0.
- Arithmetic and x0 sequence: lui x10,0x12345 / addi x10,x10,0x678 / sub x11,x10,x10 / addi x0,x0,7 / ebreak -> halt_code=32'h12345678; x11=0; x0 stays 0.
- Jumps:
  - jal x1,+8 at 80000000 -> x1=80000004, next fetch 80000008.
  - jalr x0,0(x1) -> next fetch 80000004.
  - jalr with target 80000011 -> pc 80000010 (bit0 cleared).
- Fetch stall: hold if_valid=0 for 5 cycles after reset, then present addi -> if_req stays high, pc=80000000 throughout, exactly one retire after valid.
- Illegal and reset recovery: if_inst=32'h00000000 -> halted=1, halt_code=FFFFFFFF, no retire, if_req=0. Then assert rst mid-HALT -> halted=0, pc=80000000, fetch resumes.
- With NPC_RVE_EN: addi x16,x0,1 -> illegal halt. Without the macro the same word -> x16=1, retire.
